mem_ctrl: RTL and testbench

Memory controller that services the memEN/RW/MFC handshake driven by the instruction-fetch and execute FSMs. Latches address, direction and write data at request start, inserts a parameterised number of wait states, then performs one access to an internal word-addressed RAM. Asserts MFC (memory function complete) and holds it until the requester releases memEN. Sits between MAR/MDR and the memory array, directly upstream of the fetch FSM's MFC input.

---
 rtl/mem_ctrl.sv | 110 +++++++++++
 tb/tb_mem_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: memEN/RW/MFC handshake memory controller with a parameterised
// wait-state count ahead of a single access to an internal word-addressed RAM.
`default_nettype none

module mem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memEN,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              MFC,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Counter is loaded with N-1 so that WAIT spans exactly N cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (memEN) begin
          addr_d  = addr;
          rw_d    = RW;
          wdata_d = wdata;
          if (WAIT_STATES == 0) begin
            state_d = S_ACCESS;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!memEN) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        if (rw_q) rdata_d = mem[addr_q];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!memEN) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM has no reset; a reset during WAIT leaves state_q out of ACCESS, so nothing commits.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && !rw_q) mem[addr_q] <= wdata_q;
  end

  assign rdata = rdata_q;
  assign MFC   = (state_q == S_DONE);
  assign busy  = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scoreboard bench for mem_ctrl (default and zero-wait instances).
`default_nettype none

module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_a = 1'b0, rw_a = 1'b0, en_z = 1'b0, rw_z = 1'b0;
  logic [7:0]  addr_a = '0, addr_z = '0;
  logic [15:0] wd_a = '0, wd_z = '0;
  logic [15:0] rd_a, rd_z;
  logic        mfc_a, mfc_z, busy_a, busy_z;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] model_a [256];
  logic [15:0] model_z [256];
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  mem_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(2)) u_a (
    .clk(clk), .rst(rst), .memEN(en_a), .RW(rw_a), .addr(addr_a), .wdata(wd_a),
    .rdata(rd_a), .MFC(mfc_a), .busy(busy_a)
  );

  mem_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(0)) u_z (
    .clk(clk), .rst(rst), .memEN(en_z), .RW(rw_z), .addr(addr_z), .wdata(wd_z),
    .rdata(rd_z), .MFC(mfc_z), .busy(busy_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full handshake on instance A (z=0) or the zero-wait instance (z=1).
  task automatic txn(input bit z, input logic rw, input logic [7:0] a, input logic [15:0] d,
                     input int hold, input bit chg);
    int lat;
    logic [15:0] exp;
    if (z) begin en_z = 1'b1; rw_z = rw; addr_z = a; wd_z = d; end
    else   begin en_a = 1'b1; rw_a = rw; addr_a = a; wd_a = d; end
    if (rw) sb.push_back(z ? model_z[a] : model_a[a]);
    else if (z) model_z[a] = d;
    else        model_a[a] = d;
    lat = 0;
    do begin
      tick();
      lat++;
      if (chg && lat == 1) begin
        if (z) begin addr_z = a + 8'd1; wd_z = ~d; rw_z = ~rw; end
        else   begin addr_a = a + 8'd1; wd_a = ~d; rw_a = ~rw; end
      end
    end while (!(z ? mfc_z : mfc_a) && lat < 20);
    check(z ? "latency_z" : "latency_a", lat, z ? 2 : 4);
    if (rw) begin
      exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      check(z ? "rdata_z" : "rdata_a", z ? rd_z : rd_a, exp);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_mfc", z ? mfc_z : mfc_a, 1);
      check("hold_busy", z ? busy_z : busy_a, 1);
    end
    if (z) en_z = 1'b0; else en_a = 1'b0;
    tick();
    check(z ? "release_mfc_z" : "release_mfc_a", z ? mfc_z : mfc_a, 0);
    check(z ? "release_busy_z" : "release_busy_a", z ? busy_z : busy_a, 0);
  endtask

  initial begin
    #2;
    check("reset_mfc", mfc_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_rdata", rd_a, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Write then read, with the read held for 5 cycles after MFC.
    txn(1'b0, 1'b0, 8'h12, 16'hBEEF, 0, 1'b0);
    txn(1'b0, 1'b1, 8'h12, 16'h0000, 5, 1'b0);
    check("hold_rdata", rd_a, 16'hBEEF);

    // Abort during the first WAIT cycle: no write commits, MFC never rises.
    txn(1'b0, 1'b0, 8'h05, 16'hAAAA, 0, 1'b0);
    en_a = 1'b1; rw_a = 1'b0; addr_a = 8'h05; wd_a = 16'h1234;
    tick();
    check("abort_busy_wait", busy_a, 1);
    en_a = 1'b0;
    tick();
    check("abort_busy", busy_a, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_mfc", mfc_a, 0);
    end
    txn(1'b0, 1'b1, 8'h05, 16'h0000, 0, 1'b0);

    // Inputs changed mid-flight are ignored.
    txn(1'b0, 1'b0, 8'h20, 16'h0F0F, 0, 1'b0);
    txn(1'b0, 1'b0, 8'h21, 16'h1111, 0, 1'b0);
    txn(1'b0, 1'b1, 8'h20, 16'h0000, 0, 1'b1);
    txn(1'b0, 1'b1, 8'h21, 16'h0000, 0, 1'b0);

    // Zero wait-state instance.
    txn(1'b1, 1'b0, 8'hFF, 16'h7E57, 0, 1'b0);
    txn(1'b1, 1'b1, 8'hFF, 16'h0000, 0, 1'b0);
    txn(1'b1, 1'b0, 8'h00, 16'h0001, 0, 1'b0);
    txn(1'b1, 1'b1, 8'hFF, 16'h0000, 0, 1'b0);
    txn(1'b1, 1'b1, 8'h00, 16'h0000, 0, 1'b0);

    // Asynchronous reset while in WAIT (rdata currently nonzero).
    en_a = 1'b1; rw_a = 1'b1; addr_a = 8'h12;
    tick();
    check("pre_reset_busy", busy_a, 1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_mfc", mfc_a, 0);
    check("async_reset_busy", busy_a, 0);
    check("async_reset_rdata", rd_a, 0);
    en_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("post_reset_busy", busy_a, 0);
    check("post_reset_mfc", mfc_a, 0);
    txn(1'b0, 1'b1, 8'h12, 16'h0000, 0, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
